// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch slice: default widths, PC step and reset vector.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop, full;

  assign full    = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && valid_o && !flush_i;

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // The producer's credit scheme must never push into a full queue without a matching pop.
  assert property (@(posedge clk) disable iff (rst) !(do_push && !do_pop && full));

endmodule : fetch_fifo

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-limited sequential fetch, one-deep in-flight tracking,
// redirect/flush handling and a decoupling queue towards decode.
module ifetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int unsigned CW = cnt_width(FQ_DEPTH);
  localparam int unsigned EW = XLEN + INSTR_W;

  if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ifetch_unit: FQ_DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            kill;
  logic            credit_ok;
  logic [CW:0]     outstanding;
  logic [CW-1:0]   fq_count;
  logic [EW-1:0]   fq_head;
  logic            fq_push, fq_pop;

  // Reset or redirect cancels everything in flight, including a response arriving this cycle.
  assign kill = rst || redirect_valid;

  // Queued plus in-flight entries must leave room for every response that can still land.
  assign outstanding = {1'b0, fq_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok   = (outstanding < (CW+1)'(FQ_DEPTH));

  assign imem_req  = !kill && credit_ok;
  assign imem_addr = fetch_pc_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= imem_req;
      if (imem_req) inflight_pc_q <= fetch_pc_q;
    end
  end

  assign fq_push = inflight_q && !kill;
  assign fq_pop  = out_valid && out_ready && !kill;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (fq_push),
    .wdata_i ({inflight_pc_q, imem_rdata}),
    .pop_i   (fq_pop),
    .rdata_o (fq_head),
    .valid_o (out_valid),
    .count_o (fq_count)
  );

  assign out_pc    = fq_head[INSTR_W +: XLEN];
  assign out_instr = fq_head[INSTR_W-1:0];

endmodule : ifetch_unit
